// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: coin credit accumulation, per-product
// stock tracking, single-cycle vend and refund phases, bulk restock.
//
//  state     | meaning
//  ----------+-------------------------------------------------------
//  S_IDLE    | no credit held; coins open a transaction, restock allowed
//  S_COLLECT | credit held; waiting for more coins, a selection or cancel
//  S_VEND    | dispense pulse cycle; remainder decides refund or idle
//  S_REFUND  | change pulse cycle; credit returned, back to idle next
module vend_ctrl_multi #(
  parameter int N_PROD     = 4,
  parameter int AMT_W      = 6,
  parameter int PRICE_STEP = 5,
  parameter int MAX_CREDIT = 40,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 8,
  parameter int SEL_W      = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coin_valid,
  input  logic [AMT_W-1:0]  coin_amt,
  input  logic              sel_valid,
  input  logic [SEL_W-1:0]  sel_id,
  input  logic              cancel,
  input  logic              restock,
  output logic [AMT_W-1:0]  credit,
  output logic              coin_accept,
  output logic              coin_reject,
  output logic              sel_reject,
  output logic              vend,
  output logic [SEL_W-1:0]  vend_id,
  output logic              change_valid,
  output logic [AMT_W-1:0]  change_amt,
  output logic [N_PROD-1:0] sold_out,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_REFUND} state_t;

  state_t               state;
  logic [STOCK_W-1:0]   stock [N_PROD];

  logic [AMT_W:0]       coin_sum;
  logic                 coin_nz;
  logic                 coin_ok;
  logic [AMT_W:0]       sel_price;
  logic                 sel_ok;

  // Coin acceptance check, evaluated one bit wider so overflow cannot hide a ceiling breach
  always_comb begin
    coin_sum = {1'b0, credit} + {1'b0, coin_amt};
    coin_nz  = coin_valid && (coin_amt != '0);
    coin_ok  = coin_nz && (coin_sum <= (AMT_W+1)'(MAX_CREDIT));
  end

  // Selection legality: index in range, product in stock, enough credit
  always_comb begin
    sel_price = '0;
    sel_ok    = 1'b0;
    if (int'(sel_id) < N_PROD) begin
      sel_price = (AMT_W+1)'((int'(sel_id) + 1) * PRICE_STEP);
      sel_ok    = !sold_out[sel_id] && ({1'b0, credit} >= sel_price);
    end
  end

  // Sold-out flags follow the stock counters directly
  always_comb begin
    sold_out = '0;
    for (int i = 0; i < N_PROD; i++) sold_out[i] = (stock[i] == '0);
  end

  // Main controller: state, credit, stock and all registered pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      credit       <= '0;
      coin_accept  <= 1'b0;
      coin_reject  <= 1'b0;
      sel_reject   <= 1'b0;
      vend         <= 1'b0;
      vend_id      <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      busy         <= 1'b0;
      for (int i = 0; i < N_PROD; i++) stock[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      coin_accept  <= 1'b0;
      coin_reject  <= 1'b0;
      sel_reject   <= 1'b0;
      vend         <= 1'b0;
      vend_id      <= '0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      case (state)
        S_IDLE: begin
          // nothing to buy with zero credit; cancel has nothing to refund
          if (sel_valid) sel_reject <= 1'b1;
          if (coin_ok) begin
            credit      <= coin_sum[AMT_W-1:0];
            coin_accept <= 1'b1;
            state       <= S_COLLECT;
          end else if (coin_nz) begin
            coin_reject <= 1'b1;
          end
          if (restock)
            for (int i = 0; i < N_PROD; i++) stock[i] <= STOCK_W'(STOCK_INIT);
        end
        S_COLLECT: begin
          if (cancel) begin
            change_valid <= 1'b1;
            change_amt   <= credit;
            credit       <= '0;
            state        <= S_REFUND;
            busy         <= 1'b1;
            if (coin_nz) coin_reject <= 1'b1;
          end else if (sel_valid && sel_ok) begin
            vend           <= 1'b1;
            vend_id        <= sel_id;
            credit         <= credit - sel_price[AMT_W-1:0];
            stock[sel_id]  <= stock[sel_id] - 1'b1;
            state          <= S_VEND;
            busy           <= 1'b1;
            if (coin_nz) coin_reject <= 1'b1;
          end else begin
            // a refused selection does not consume the coin slot
            if (sel_valid) sel_reject <= 1'b1;
            if (coin_ok) begin
              credit      <= coin_sum[AMT_W-1:0];
              coin_accept <= 1'b1;
            end else if (coin_nz) begin
              coin_reject <= 1'b1;
            end
          end
        end
        S_VEND: begin
          if (coin_nz)   coin_reject <= 1'b1;
          if (sel_valid) sel_reject  <= 1'b1;
          if (credit != '0) begin
            change_valid <= 1'b1;
            change_amt   <= credit;
            credit       <= '0;
            state        <= S_REFUND;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          if (coin_nz)   coin_reject <= 1'b1;
          if (sel_valid) sel_reject  <= 1'b1;
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi at default parameters (prices 5/10/15/20,
// ceiling 40, stock 8 per product).
module tb_vend_ctrl_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid;
  logic [5:0] coin_amt;
  logic       sel_valid;
  logic [1:0] sel_id;
  logic       cancel;
  logic       restock;
  logic [5:0] credit;
  logic       coin_accept, coin_reject, sel_reject, vend, change_valid, busy;
  logic [1:0] vend_id;
  logic [5:0] change_amt;
  logic [3:0] sold_out;

  int vecs = 0;
  int errs = 0;

  vend_ctrl_multi dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_amt(coin_amt),
    .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .restock(restock),
    .credit(credit), .coin_accept(coin_accept), .coin_reject(coin_reject),
    .sel_reject(sel_reject), .vend(vend), .vend_id(vend_id),
    .change_valid(change_valid), .change_amt(change_amt),
    .sold_out(sold_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    coin_valid = 1'b0; coin_amt = '0; sel_valid = 1'b0; sel_id = '0;
    cancel = 1'b0; restock = 1'b0;
  endtask

  task automatic coin(input int amt);
    coin_valid = 1'b1; coin_amt = 6'(amt);
    tick();
    idle_inputs();
  endtask

  task automatic sel(input int id);
    sel_valid = 1'b1; sel_id = 2'(id);
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // reset state
    chk("rst_credit", credit, 0);
    chk("rst_sold_out", sold_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {vend, change_valid, coin_accept, coin_reject, sel_reject}, 0);
    chk("rst_stock0", dut.stock[0], 8);

    // 1: exact payment, no change
    coin(5);
    chk("t1_accept", coin_accept, 1);
    chk("t1_credit", credit, 5);
    sel(0);
    chk("t1_vend", vend, 1);
    chk("t1_vend_id", vend_id, 0);
    chk("t1_credit_after", credit, 0);
    chk("t1_stock0", dut.stock[0], 7);
    tick();
    chk("t1_no_change", change_valid, 0);
    chk("t1_idle", busy, 0);

    // 2: overpay, change follows vend; coin during VEND refused
    coin(5);
    coin(10);
    chk("t2_credit", credit, 15);
    sel(1);
    chk("t2_vend", vend, 1);
    chk("t2_vend_id", vend_id, 1);
    coin_valid = 1'b1; coin_amt = 6'd5;
    tick();
    idle_inputs();
    chk("t2_busy_coin_rej", coin_reject, 1);
    chk("t2_change_valid", change_valid, 1);
    chk("t2_change_amt", change_amt, 5);
    chk("t2_vend_low", vend, 0);
    chk("t2_credit_zero", credit, 0);
    tick();
    chk("t2_change_done", change_valid, 0);
    chk("t2_idle", busy, 0);

    // 3: insufficient credit, then cancel
    coin(10);
    sel(3);
    chk("t3_sel_reject", sel_reject, 1);
    chk("t3_no_vend", vend, 0);
    chk("t3_credit", credit, 10);
    cancel = 1'b1;
    tick();
    idle_inputs();
    chk("t3_refund_valid", change_valid, 1);
    chk("t3_refund_amt", change_amt, 10);
    tick();
    chk("t3_credit_zero", credit, 0);
    chk("t3_amt_cleared", change_amt, 0);

    // 4: credit ceiling, coin+selection collision
    coin(20);
    coin(20);
    chk("t4_credit40", credit, 40);
    coin(5);
    chk("t4_ceiling_rej", coin_reject, 1);
    chk("t4_credit_held", credit, 40);
    coin_valid = 1'b1; coin_amt = 6'd5; sel_valid = 1'b1; sel_id = 2'd0;
    tick();
    idle_inputs();
    chk("t4_collide_rej", coin_reject, 1);
    chk("t4_collide_vend", vend, 1);
    chk("t4_credit35", credit, 35);
    tick();
    chk("t4_change35", change_amt, 35);
    tick();

    // 5: drain product 2, sold-out refusal, restock
    for (int n = 0; n < 8; n++) begin
      coin(15);
      sel(2);
      chk("t5_vend", {vend, vend_id}, {1'b1, 2'd2});
      tick();
    end
    chk("t5_sold_out", sold_out, 4'b0100);
    coin(15);
    sel(2);
    chk("t5_soldout_rej", sel_reject, 1);
    chk("t5_soldout_novend", vend, 0);
    cancel = 1'b1;
    tick();
    idle_inputs();
    chk("t5_refund15", change_amt, 15);
    tick();
    restock = 1'b1;
    tick();
    idle_inputs();
    chk("t5_restock_flags", sold_out, 0);
    chk("t5_restock_stock2", dut.stock[2], 8);
    chk("t5_restock_stock0", dut.stock[0], 8);

    // 6: reset mid-transaction
    coin(10);
    sel(1);
    tick();
    chk("t6_stock1", dut.stock[1], 7);
    coin(15);
    chk("t6_credit15", credit, 15);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t6_credit_zero", credit, 0);
    chk("t6_no_change", change_valid, 0);
    chk("t6_not_busy", busy, 0);
    chk("t6_stock1_reload", dut.stock[1], 8);
    coin(5);
    chk("t6_idle_accept", coin_accept, 1);
    chk("t6_idle_credit", credit, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
